alu_share_arbiter: RTL and testbench

Shares one combinational `alu` instance between two requesters (r0: execute-stage integer path, r1: branch/address-compare path) using valid/ready handshakes on both request and response sides. Round-robin arbitration picks one request per cycle. The chosen operation is evaluated and its result registered into a single response holding slot tagged with the owner. It sits between the pipeline issue logic and the datapath ALU and also counts completed operations.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu.sv | 32 +++
 rtl/alu_share_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes, opcode legality check and arbiter state type
// Contents:
//   ALU_* opcode localparams, op_legal(), arb_state_t {IDLE, HOLD}
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [OP_W-1:0] ALU_NE  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0100;
    localparam logic [OP_W-1:0] ALU_XOR = 4'b0101;
    localparam logic [OP_W-1:0] ALU_EQ  = 4'b1000;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        logic ok;
        case (op)
            ALU_AND, ALU_SUB, ALU_ADD, ALU_NE,
            ALU_OR, ALU_XOR, ALU_EQ: ok = 1'b1;
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer ALU shared by the arbiter
// Ports:
//   srca, srcb  in  DATA_WIDTH     operands
//   alucontrol  in  OPCODE_LENGTH  operation code
//   aluresult   out DATA_WIDTH     result (0 for unsupported opcodes)
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    srca,
    input  logic [DATA_WIDTH-1:0]    srcb,
    input  logic [OPCODE_LENGTH-1:0] alucontrol,
    output logic [DATA_WIDTH-1:0]    aluresult
);

    always_comb begin
        aluresult = '0;
        case (alucontrol)
            ALU_AND: aluresult = srca & srcb;
            ALU_SUB: aluresult = srca - srcb;
            ALU_ADD: aluresult = srca + srcb;
            ALU_NE:  aluresult = {{(DATA_WIDTH-1){1'b0}}, srca != srcb};
            ALU_OR:  aluresult = srca | srcb;
            ALU_XOR: aluresult = srca ^ srcb;
            ALU_EQ:  aluresult = {{(DATA_WIDTH-1){1'b0}}, srca == srcb};
            default: aluresult = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between two requesters
// Ports:
//   clk, reset                    clock, async active-high reset
//   rN_req_valid / rN_req_ready   request handshake (ready = grant)
//   rN_srca, rN_srcb, rN_op       operands and opcode, sampled only on grant
//   rN_rsp_valid / rN_rsp_ready   response handshake for the slot owner
//   rsp_data, rsp_illegal         held result and unsupported-opcode flag
//   ops_done                      completed response count, wraps
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     r0_req_valid,
    output logic                     r0_req_ready,
    input  logic [DATA_WIDTH-1:0]    r0_srca,
    input  logic [DATA_WIDTH-1:0]    r0_srcb,
    input  logic [OPCODE_LENGTH-1:0] r0_op,
    input  logic                     r1_req_valid,
    output logic                     r1_req_ready,
    input  logic [DATA_WIDTH-1:0]    r1_srca,
    input  logic [DATA_WIDTH-1:0]    r1_srcb,
    input  logic [OPCODE_LENGTH-1:0] r1_op,
    output logic                     r0_rsp_valid,
    input  logic                     r0_rsp_ready,
    output logic                     r1_rsp_valid,
    input  logic                     r1_rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     rsp_illegal,
    output logic [CNT_WIDTH-1:0]     ops_done
);

    arb_state_t              state_q, state_d;
    logic                    owner_q;
    logic                    rr_ptr_q;
    logic [DATA_WIDTH-1:0]   res_q;
    logic                    illegal_q;
    logic [CNT_WIDTH-1:0]    ops_done_q;

    logic                    owner_rsp_ready;
    logic                    drain;
    logic                    free;
    logic                    gnt0, gnt1, gnt_any;
    logic [DATA_WIDTH-1:0]   mux_a, mux_b, alu_y;
    logic [OPCODE_LENGTH-1:0] mux_op;

    // Only the owner's rsp_ready matters; the other requester's is ignored.
    assign owner_rsp_ready = owner_q ? r1_rsp_ready : r0_rsp_ready;
    assign drain           = (state_q == HOLD) && owner_rsp_ready;
    // Draining slot counts as free so a new grant can land in the same cycle.
    assign free            = (state_q == IDLE) || drain;

    always_comb begin
        gnt0 = free && !reset && r0_req_valid && (!r1_req_valid || !rr_ptr_q);
        gnt1 = free && !reset && r1_req_valid && (!r0_req_valid ||  rr_ptr_q);
    end

    assign gnt_any      = gnt0 || gnt1;
    assign r0_req_ready = gnt0;
    assign r1_req_ready = gnt1;

    // Operand mux defaults to r0 when nothing is granted; the result is only
    // captured on a grant.
    assign mux_a  = gnt1 ? r1_srca : r0_srca;
    assign mux_b  = gnt1 ? r1_srcb : r0_srcb;
    assign mux_op = gnt1 ? r1_op   : r0_op;

    alu #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_alu (
        .srca       (mux_a),
        .srcb       (mux_b),
        .alucontrol (mux_op),
        .aluresult  (alu_y)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (gnt_any)    state_d = HOLD;
        else if (drain) state_d = IDLE;
    end

    // Output logic: registered state only, no path from rsp_ready
    always_comb begin
        r0_rsp_valid = (state_q == HOLD) && !owner_q;
        r1_rsp_valid = (state_q == HOLD) &&  owner_q;
    end

    // Response slot, round-robin pointer and completion counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            res_q      <= '0;
            illegal_q  <= 1'b0;
            ops_done_q <= '0;
        end else begin
            if (gnt_any) begin
                res_q     <= alu_y;
                illegal_q <= !op_legal(mux_op);
                owner_q   <= gnt1;
                rr_ptr_q  <= !gnt1;
            end
            if (drain) ops_done_q <= ops_done_q + 1'b1;
        end
    end

    assign rsp_data    = res_q;
    assign rsp_illegal = illegal_q;
    assign ops_done    = ops_done_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter
module tb_alu_share_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          r0_req_valid = 1'b0, r1_req_valid = 1'b0;
    logic          r0_req_ready, r1_req_ready;
    logic [DW-1:0] r0_srca = '0, r0_srcb = '0, r1_srca = '0, r1_srcb = '0;
    logic [OW-1:0] r0_op = '0, r1_op = '0;
    logic          r0_rsp_valid, r1_rsp_valid;
    logic          r0_rsp_ready = 1'b0, r1_rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_illegal;
    logic [CW-1:0] ops_done;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
        .r0_srca(r0_srca), .r0_srcb(r0_srcb), .r0_op(r0_op),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
        .r1_srca(r1_srca), .r1_srcb(r1_srcb), .r1_op(r1_op),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .rsp_data(rsp_data), .rsp_illegal(rsp_illegal), .ops_done(ops_done)
    );

    typedef struct {
        bit            owner;
        logic [DW-1:0] data;
        bit            ill;
    } rsp_t;

    rsp_t          q[$];
    int            tests = 0;
    int            fails = 0;
    int            cnt = 0;
    bit            in_reset = 1'b1;
    bit            last = 1'b1;
    bit            pv[2];
    logic [DW-1:0] pa[2], pb[2];
    logic [OW-1:0] pop[2];
    bit            rr[2];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [OW-1:0] op, input bit owner);
        rsp_t r;
        r.owner = owner;
        r.ill   = 1'b0;
        case (op)
            4'd0: r.data = a & b;
            4'd1: r.data = a - b;
            4'd2: r.data = a + b;
            4'd3: r.data = (a != b) ? 1 : 0;
            4'd4: r.data = a | b;
            4'd5: r.data = a ^ b;
            4'd8: r.data = (a == b) ? 1 : 0;
            default: begin r.data = 0; r.ill = 1'b1; end
        endcase
        return r;
    endfunction

    // Monitor: compares the held response against the head of the scoreboard.
    always @(negedge clk) begin
        bit e0, e1;
        if (!in_reset) begin
            e0 = (q.size() > 0) && (q[0].owner == 1'b0);
            e1 = (q.size() > 0) && (q[0].owner == 1'b1);
            chk("r0_rsp_valid", r0_rsp_valid, e0);
            chk("r1_rsp_valid", r1_rsp_valid, e1);
            chk("ops_done", ops_done, cnt % 16);
            if (q.size() > 0) begin
                chk("rsp_data", rsp_data, q[0].data);
                chk("rsp_illegal", rsp_illegal, q[0].ill);
                if (rr[q[0].owner]) begin
                    void'(q.pop_front());
                    cnt = (cnt + 1) % 16;
                end
            end
        end
    end

    task automatic drive();
        r0_req_valid = pv[0]; r0_srca = pa[0]; r0_srcb = pb[0]; r0_op = pop[0];
        r1_req_valid = pv[1]; r1_srca = pa[1]; r1_srcb = pb[1]; r1_op = pop[1];
        r0_rsp_ready = rr[0]; r1_rsp_ready = rr[1];
    endtask

    task automatic offer(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [OW-1:0] op);
        if (!pv[n]) begin
            pv[n] = 1'b1; pa[n] = a; pb[n] = b; pop[n] = op;
        end
    endtask

    // One cycle: drive after the edge, predict and check the grant mid-cycle.
    task automatic step(input bit rdy0, input bit rdy1);
        bit free, g0, g1, n;
        @(posedge clk); #1;
        rr[0] = rdy0; rr[1] = rdy1;
        drive();
        @(negedge clk); #1;
        free = (q.size() == 0);
        g0 = 1'b0; g1 = 1'b0;
        if (free) begin
            if (pv[0] && pv[1]) begin
                if (last) g0 = 1'b1; else g1 = 1'b1;
            end else if (pv[0]) g0 = 1'b1;
            else if (pv[1]) g1 = 1'b1;
        end
        chk("r0_req_ready", r0_req_ready, g0);
        chk("r1_req_ready", r1_req_ready, g1);
        if (g0 || g1) begin
            n = g1;
            q.push_back(model(pa[n], pb[n], pop[n], n));
            pv[n] = 1'b0;
            last = n;
        end
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        reset = 1'b1;
        r0_req_valid = 1'b1; r1_req_valid = 1'b1;
        #1;
        chk("rst_r0_req_ready", r0_req_ready, 0);
        chk("rst_r1_req_ready", r1_req_ready, 0);
        chk("rst_r0_rsp_valid", r0_rsp_valid, 0);
        chk("rst_r1_rsp_valid", r1_rsp_valid, 0);
        chk("rst_ops_done", ops_done, 0);
        q.delete();
        pv[0] = 1'b0; pv[1] = 1'b0;
        rr[0] = 1'b0; rr[1] = 1'b0;
        last = 1'b1;
        cnt = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        in_reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            pv[i] = 0; pa[i] = 0; pb[i] = 0; pop[i] = 0; rr[i] = 0;
        end
        #2;
        do_reset();

        // Idle after reset, then reset while r0 holds a result.
        step(0, 0);
        offer(0, 32'd1, 32'd2, 4'd2);
        step(0, 0);
        step(0, 0);
        #2;
        do_reset();

        // r0 ADD 7+5 with three cycles of backpressure; r1 waits meanwhile.
        offer(0, 32'd7, 32'd5, 4'd2);
        step(0, 0);
        offer(1, 32'h33, 32'h11, 4'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            chk("add_hold_data", rsp_data, 32'd12);
        end
        step(1, 0);
        // r1 holds; r0 waits, then is granted on r1's drain cycle.
        offer(0, 32'hA, 32'h6, 4'd0);
        step(0, 0);
        step(0, 1);
        step(1, 0);
        step(0, 0);
        chk("ops_done_after_directed", ops_done, 4'd3);

        // Both valid every cycle: grants alternate, one response per cycle.
        for (int i = 0; i < 8; i++) begin
            offer(0, 32'd10, 32'd3, 4'd1);
            offer(1, 32'hF0, 32'h0F, 4'd5);
            step(1, 1);
        end

        // Compare ops and an unsupported opcode.
        offer(0, 32'd5, 32'd5, 4'd3); step(1, 1);
        offer(0, 32'd5, 32'd5, 4'd8); step(1, 1);
        offer(1, 32'd9, 32'd4, 4'd6); step(1, 1);
        step(1, 1);
        step(1, 1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pv[n] && ($urandom_range(0, 9) < 7)) begin
                    logic [DW-1:0] a, b;
                    a = $urandom();
                    b = ($urandom_range(0, 3) == 0) ? a : $urandom();
                    offer(n, a, b, 4'($urandom_range(0, 15)));
                end
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        // Drain everything, bounded.
        for (int i = 0; i < 10; i++) begin
            if (q.size() != 0 || pv[0] || pv[1]) step(1, 1);
        end
        chk("final_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
